// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the serial receive path.
//   rx_state_t   : receiver FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS    : data bits per frame (8N1 framing)
// SYNC_STAGES    : flop count of the input-pin synchronizers
//   cnt_width()  : width of a counter that spans one bit period
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  // A one-clock bit period would give $clog2 == 0, so keep at least one bit.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic flop-chain synchronizer for asynchronous input pins.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; every stage loads RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, STAGES clocks behind d
// RESET_VAL should match the idle level of the pin (1 for a serial line) so
// that leaving reset never looks like an edge on the line.
// ---------------------------------------------------------------------------
module sync_2ff
  import serial_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1,
  parameter int   STAGES    = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// ---------------------------------------------------------------------------
// serial_rx
// 8N1 asynchronous serial receiver with a one-entry valid/ready output buffer.
//   CLKS_PER_BIT : clocks per serial bit (even, >= 4)
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ena          : design enable; low holds the receiver in IDLE
//   rx           : raw serial line, idle high, unsynchronized
//   rx_data      : held byte (keeps its last value after consumption)
//   rx_valid     : rx_data holds an unconsumed byte
//   rx_ready     : consumer takes rx_data when rx_valid && rx_ready
//   frame_err    : one-cycle pulse when a stop bit is sampled low
//   overrun      : sticky; a completed byte was dropped (cleared by reset only)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitn;
  logic [DATA_BITS-1:0] shreg;

  sync_2ff #(
    .RESET_VAL (1'b1),
    .STAGES    (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Receiver FSM and output buffer share one block so that a completing byte
  // and a consumer handshake on the same edge resolve in one place: the load
  // below overrides the consume-clear, which keeps rx_valid high with the new
  // byte instead of dropping it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (!ena) begin
        state <= IDLE;
        cnt   <= '0;
        bitn  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end

          // Re-check the line half a bit in; a pulse that has already gone
          // high again is treated as a glitch.
          START: begin
            if (cnt == HALF_LAST) begin
              cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                bitn  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          // Sampling one full bit after the mid-start point lands mid-bit.
          // LSB arrives first, so shift right and insert at the top.
          DATA: begin
            if (cnt == FULL_LAST) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bitn == LAST_BIT) begin
                state <= STOP;
              end else begin
                bitn <= bitn + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          // Return to IDLE on the stop-sample edge itself, half a bit early,
          // so a start bit that immediately follows is not missed.
          STOP: begin
            if (cnt == FULL_LAST) begin
              cnt   <= '0;
              state <= IDLE;
              if (rx_s) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_rx
// Self-checking bench for serial_rx (CLKS_PER_BIT = 16). Bytes that should
// reach the consumer are queued when their frame is driven; a negedge monitor
// pops and compares one entry at every valid/ready handshake. Directed checks
// cover timing, glitches, framing errors, overrun, same-edge consume, reset
// and enable behaviour.
// ---------------------------------------------------------------------------
module tb_serial_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];

  int   valid_rises   = 0;
  int   valid_high    = 0;
  int   last_rise_cyc = -1;
  int   ferr_pulses   = 0;
  int   ferr_high     = 0;
  int   last_ferr_cyc = -1;
  logic valid_prev    = 1'b0;
  logic ferr_prev     = 1'b0;

  serial_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Free-running clock and cycle count; cyc read #1 after an edge names it.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Event counters plus the scoreboard: a handshake seen at a negedge is taken
  // by the DUT at the following posedge, so the held byte is compared here.
  always @(negedge clk) begin
    if (rx_valid && !valid_prev) begin
      valid_rises++;
      last_rise_cyc = cyc;
    end
    if (rx_valid) valid_high++;
    if (frame_err && !ferr_prev) begin
      ferr_pulses++;
      last_ferr_cyc = cyc;
    end
    if (frame_err) ferr_high++;
    valid_prev = rx_valid;
    ferr_prev  = frame_err;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        checkOutput("sb_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
  endtask

  // Drives one frame. e0 is the edge after which the start bit appears.
  // action: 0 none, 1 reset during bit 4, 2 ena low from bit 4,
  //         3 ready high for exactly the stop-sample edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int action, output int e0);
    @(posedge clk); #1;
    e0 = cyc;
    rx = 1'b0;
    for (int i = 0; i < C; i++) begin
      @(posedge clk); #1;
    end
    for (int b = 0; b < 8; b++) begin
      rx = data[b];
      for (int i = 0; i < C; i++) begin
        @(posedge clk); #1;
        if (b == 4 && i == 4 && action == 1) begin
          rst_n = 1'b0;
          exp_q.delete();
          #1;
          checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'h00);
          checkOutput("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
          checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);
          checkOutput("midreset_overrun", {31'd0, overrun}, 32'd0);
        end
        if (b == 4 && i == 4 && action == 2) ena = 1'b0;
      end
    end
    rx = stop_bit;
    for (int i = 0; i < C; i++) begin
      @(posedge clk); #1;
      if (action == 3 && i == 9)  rx_ready = 1'b1;
      if (action == 3 && i == 10) rx_ready = 1'b0;
    end
    rx = 1'b1;
  endtask

  initial begin
    int e0;
    int r0, h0, f0, fh0;

    rst_n    = 1'b0;
    ena      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;

    // Reset values
    waitCycles(3);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    waitCycles(4);

    // Basic byte, consumer always ready
    $display("[TB] basic byte 0xA5");
    r0 = valid_rises; h0 = valid_high; f0 = ferr_pulses;
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 0, e0);
    waitCycles(3);
    checkOutput("basic_valid_rises", 32'(valid_rises - r0), 32'd1);
    checkOutput("basic_valid_cycle", 32'(last_rise_cyc - e0), 32'd155);
    checkOutput("basic_valid_width", 32'(valid_high - h0), 32'd1);
    checkOutput("basic_rx_data", {24'd0, rx_data}, 32'hA5);
    checkOutput("basic_frame_err", 32'(ferr_pulses - f0), 32'd0);
    checkOutput("basic_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Four-cycle glitch, then a real byte
    $display("[TB] glitch then 0x3C");
    r0 = valid_rises; f0 = ferr_pulses;
    @(posedge clk); #1;
    rx = 1'b0;
    waitCycles(4);
    rx = 1'b1;
    waitCycles(30);
    checkOutput("glitch_no_valid", 32'(valid_rises - r0), 32'd0);
    checkOutput("glitch_no_frame_err", 32'(ferr_pulses - f0), 32'd0);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1, 0, e0);
    waitCycles(3);
    checkOutput("glitch_next_rises", 32'(valid_rises - r0), 32'd1);
    checkOutput("glitch_next_cycle", 32'(last_rise_cyc - e0), 32'd155);
    checkOutput("glitch_next_data", {24'd0, rx_data}, 32'h3C);

    // Framing error: stop bit low
    $display("[TB] framing error on 0x55");
    r0 = valid_rises; f0 = ferr_pulses; fh0 = ferr_high;
    applyStimulus(8'h55, 1'b0, 0, e0);
    waitCycles(30);
    checkOutput("ferr_pulses", 32'(ferr_pulses - f0), 32'd1);
    checkOutput("ferr_cycle", 32'(last_ferr_cyc - e0), 32'd155);
    checkOutput("ferr_width", 32'(ferr_high - fh0), 32'd1);
    checkOutput("ferr_no_valid", 32'(valid_rises - r0), 32'd0);
    checkOutput("ferr_data_kept", {24'd0, rx_data}, 32'h3C);

    // Overrun: two frames back-to-back with the consumer stalled
    $display("[TB] overrun 0x11 then 0x22");
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 0, e0);
    applyStimulus(8'h22, 1'b1, 0, e0);
    waitCycles(3);
    checkOutput("ovr_rx_data", {24'd0, rx_data}, 32'h11);
    checkOutput("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    rx_ready = 1'b1;
    waitCycles(3);
    checkOutput("ovr_drained_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);
    checkOutput("ovr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Consume on the same edge a new byte completes
    $display("[TB] simultaneous consume");
    applyReset();
    checkOutput("sim_overrun_cleared", {31'd0, overrun}, 32'd0);
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 0, e0);
    waitCycles(3);
    checkOutput("sim_first_valid", {31'd0, rx_valid}, 32'd1);
    exp_q.push_back(8'h22);
    applyStimulus(8'h22, 1'b1, 3, e0);
    waitCycles(3);
    checkOutput("sim_rx_data", {24'd0, rx_data}, 32'h22);
    checkOutput("sim_rx_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("sim_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("sim_queue_pending", 32'(exp_q.size()), 32'd1);
    rx_ready = 1'b1;
    waitCycles(3);
    checkOutput("sim_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during bit 4 with a held byte and overrun set
    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    exp_q.push_back(8'h96);
    applyStimulus(8'h96, 1'b1, 0, e0);
    applyStimulus(8'h69, 1'b1, 0, e0);
    waitCycles(3);
    checkOutput("pre_reset_overrun", {31'd0, overrun}, 32'd1);
    applyStimulus(8'h22, 1'b1, 1, e0);
    rst_n = 1'b1;
    waitCycles(4);
    rx_ready = 1'b1;
    r0 = valid_rises;
    exp_q.push_back(8'hC3);
    applyStimulus(8'hC3, 1'b1, 0, e0);
    waitCycles(3);
    checkOutput("post_reset_rises", 32'(valid_rises - r0), 32'd1);
    checkOutput("post_reset_cycle", 32'(last_rise_cyc - e0), 32'd155);
    checkOutput("post_reset_data", {24'd0, rx_data}, 32'hC3);
    checkOutput("post_reset_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("post_reset_queue", 32'(exp_q.size()), 32'd0);

    // ena dropped mid-frame while a byte is held
    $display("[TB] ena low mid-frame");
    rx_ready = 1'b0;
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1, 0, e0);
    waitCycles(3);
    r0 = valid_rises; f0 = ferr_pulses;
    applyStimulus(8'hC3, 1'b1, 2, e0);
    waitCycles(3);
    ena = 1'b1;
    waitCycles(20);
    checkOutput("ena_no_new_byte", 32'(valid_rises - r0), 32'd0);
    checkOutput("ena_valid_held", {31'd0, rx_valid}, 32'd1);
    checkOutput("ena_data_held", {24'd0, rx_data}, 32'h5A);
    checkOutput("ena_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("ena_frame_err", 32'(ferr_pulses - f0), 32'd0);
    rx_ready = 1'b1;
    waitCycles(3);
    checkOutput("ena_drained_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
# serial_rx

Receiving end of the asynchronous 8N1 serial stream the host/bench drives onto a dedicated input pin (`ui_in[3]`) of `tt_um_pkuligowski_top`. It synchronizes the line, detects start bits, samples mid-bit, checks the stop bit, and presents each received byte to the core through a one-entry valid/ready buffer. It also reports framing errors and overruns. The block sits between the top-level pin map and the core's byte consumer (program loader / debug port).

## Interface

- `CLKS_PER_BIT`, default 16: clocks per serial bit. Must be even and ≥ 4.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ena`, in, 1: design enable. While low, the FSM is held in IDLE.
- `rx`, in, 1: raw serial line, idle high, unsynchronized.
- `rx_data`, out, 8: held byte. Reset value 8'h00.
- `rx_valid`, out, 1: `rx_data` is valid. Reset value 0.
- `rx_ready`, in, 1: consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `frame_err`, out, 1: one-cycle pulse on a bad stop bit. Reset value 0.
- `overrun`, out, 1: sticky flag set when a completed byte is dropped. Reset value 0; cleared only by reset.

## Operation

- **Synchronizer.** `rx` passes through 2 flops (both reset to 1). The synchronized output is `rx_s`. All decisions use `rx_s`.
- **Definitions.** H = CLKS_PER_BIT/2; C = CLKS_PER_BIT. `cnt` is the bit-timing counter, `bitn` counts data bits 0..7, `shreg` is the receive shift register.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: if `ena && !rx_s`, go to START and set cnt=0.
  - START: cnt increments each cycle. At cnt==H-1:
    - if `rx_s==0`, go to DATA with cnt=0, bitn=0;
    - otherwise (false start), go to IDLE.
  - DATA: at cnt==C-1, shift `rx_s` into `shreg` LSB-first, reset cnt to 0, increment bitn. After bit 7, go to STOP.
  - STOP: at cnt==C-1, sample `rx_s` and return to IDLE in the same edge (this permits back-to-back frames).
    - `rx_s==1`: byte completes.
    - `rx_s==0`: assert `frame_err` for 1 cycle and discard the byte.
- **Buffer**, evaluated at the byte-completion edge:
  - If the buffer is empty, or `rx_valid && rx_ready` on the same edge: load `rx_data` and set `rx_valid`=1. No overrun.
  - Else: keep the old byte, drop the new one, set `overrun`=1.
- **Consume.** `rx_valid && rx_ready` with no completion clears `rx_valid`. `rx_data` keeps its last value.
- **`ena` low.** The FSM is forced to IDLE and any partial frame is abandoned. The buffer, `rx_valid` and `overrun` are unaffected.
- **Reset mid-frame.** All state returns to reset values immediately (asynchronous). The next full frame is received normally.

## Timing

- E0 is the first rising edge at which the `rx` pin is low.
  - `rx_s` goes low after E2.
  - The FSM enters START at E3.
  - The start bit is confirmed at E3+H.
  - Data bit k (k=1..8) is sampled at E3+H+k·C.
  - The stop bit is sampled at E3+H+9·C.
- `rx_valid`/`frame_err` are high in the cycle after E3+H+9·C. For C=16 that edge is E155.
- A false start shorter than about H−? cycles is rejected at E3+H with no outputs asserted. Specifically, a low pulse that has ended before `rx_s` is sampled at E3+H produces no output.
- Throughput is one byte per 9.5·C cycles minimum. The consumer gets a full frame time to assert `rx_ready` before overrun.
- All outputs are registered. There are no combinational paths from `rx_ready` to outputs.

## Structure

- Package `serial_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP);
  - localparams `DATA_BITS`=8 and `SYNC_STAGES`=2;
  - a function computing the counter width, $clog2(CLKS_PER_BIT).
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with a parameterized reset value (1 here). It is reused for the other `ui_in` pins.
- The top integration instantiates `serial_rx` on `ui_in[3]`.

## Test plan

- **Basic byte:** C=16, ready=1, send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop). Expect `rx_data`=0xA5 and `rx_valid` high from the cycle after E155, cleared one cycle later. `frame_err`=0, `overrun`=0.
- **Glitch:** drive `rx` low for 4 cycles, then high. Expect no `rx_valid`, no `frame_err`, and the FSM back in IDLE by E3+H. A following 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit = 0. Expect a one-cycle `frame_err` pulse after E155, `rx_valid` stays 0, `rx_data` unchanged.
- **Overrun:** ready=0, send 0x11 then 0x22 back-to-back. Expect `rx_data`=0x11 still valid, `overrun`=1 after the second frame, and `overrun` stays 1 after ready=1.
- **Simultaneous consume:** hold the 0x11 byte, then pulse ready exactly on 0x22's completion edge. Expect `rx_data`=0x22, `rx_valid`=1, `overrun`=0.
- **Reset mid-frame / `ena`:** assert `rst_n`=0 during bit 4 of a frame. Expect all outputs at reset values immediately. After release, 0xC3 is received correctly. Repeat with `ena`=0 mid-frame: expect no byte and an existing held byte retained.
